// File: rtl/gpioemu_pkg.sv
// Shared definitions for the GPIO-emulated multiplier bus master: register map,
// status bits, FSM state and transfer-type encodings.
package gpioemu_pkg;

  localparam logic [15:0] ADDR_A1   = 16'h037F;
  localparam logic [15:0] ADDR_A2   = 16'h0388;
  localparam logic [15:0] ADDR_CTRL = 16'h03A0;
  localparam logic [15:0] ADDR_W    = 16'h0390;
  localparam logic [15:0] ADDR_L    = 16'h0398;

  localparam int unsigned STAT_READY = 1;
  localparam int unsigned STAT_VALID = 0;

  typedef enum logic [3:0] {
    StIdle, StWrA1, StWrA2, StWrGo, StPoll, StGap, StRdW, StRdL, StDone, StTimeout
  } state_e;

  typedef enum logic {
    XFER_WR = 1'b0,
    XFER_RD = 1'b1
  } xfer_e;

  typedef enum logic [1:0] {
    XIdle, XSetup, XStrobe, XHold
  } xphase_e;

endpackage

// File: rtl/gpioemu_bus_xfer.sv
// Single bus transfer engine: SETUP(1) + STROBE(STROBE_CYCLES) + HOLD(1), ack during HOLD.
// A go seen during HOLD chains the next transfer with no idle cycle in between.
module gpioemu_bus_xfer
  import gpioemu_pkg::*;
#(
  parameter int unsigned STROBE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        go_i,
  input  logic        is_read_i,
  input  logic [15:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] sdata_rd_i,
  output logic [31:0] rdata_o,
  output logic        ack_o,
  output logic [15:0] saddress_o,
  output logic        swr_o,
  output logic        srd_o,
  output logic [31:0] sdata_wr_o
);

  xphase_e     phase_q, phase_d;
  logic [15:0] cnt_q, cnt_d;
  logic        rd_q, rd_d;
  logic [15:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        active;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      phase_q <= XIdle;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (phase_q)
      XIdle, XHold: begin
        if (go_i) begin
          phase_d = XSetup;
          rd_d    = is_read_i;
          addr_d  = addr_i;
          wdata_d = wdata_i;
        end else begin
          phase_d = XIdle;
        end
      end
      XSetup: begin
        phase_d = XStrobe;
        cnt_d   = '0;
      end
      XStrobe: begin
        if (cnt_q == 16'(STROBE_CYCLES - 1)) begin
          phase_d = XHold;
          if (rd_q) rdata_d = sdata_rd_i;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: phase_d = XIdle;
    endcase
  end

  // Bus outputs decode straight from registers so reset removes strobes at once.
  assign active     = (phase_q != XIdle);
  assign saddress_o = active ? addr_q : 16'h0;
  assign sdata_wr_o = active ? wdata_q : 32'h0;
  assign srd_o      = (phase_q == XStrobe) && rd_q;
  assign swr_o      = (phase_q == XStrobe) && !rd_q;
  assign ack_o      = (phase_q == XHold);
  assign rdata_o    = rdata_q;

endmodule

// File: rtl/gpioemu_bus_master.sv
// Bus initiator for the emulated multiplier: load A1/A2, trigger, poll, read W (and L).
// Define GPIOEMU_BUS_MASTER_READ_L_EN to also read the ones count; otherwise ones stays 0.
module gpioemu_bus_master
  import gpioemu_pkg::*;
#(
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned POLL_MAX      = 1024,
  parameter int unsigned POLL_GAP      = 4
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        start,
  input  logic [23:0] a1,
  input  logic [23:0] a2,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [31:0] w,
  output logic [23:0] ones,
  output logic        valid,
  output logic [15:0] saddress,
  output logic        swr,
  output logic        srd,
  output logic [31:0] sdata_wr,
  input  logic [31:0] sdata_rd
);

  state_e      state_q, state_d;
  logic [23:0] a2_q, a2_d;
  logic [31:0] w_q, w_d;
  logic        valid_q, valid_d;
  logic [15:0] poll_q, poll_d, poll_inc;
  logic [15:0] gap_q, gap_d;
  logic        go, ack;
  xfer_e       go_kind;
  logic [15:0] go_addr;
  logic [31:0] go_wdata, rdata;
`ifdef GPIOEMU_BUS_MASTER_READ_L_EN
  logic [23:0] ones_q, ones_d;
`endif

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= StIdle;
      a2_q    <= '0;
      w_q     <= '0;
      valid_q <= 1'b0;
      poll_q  <= '0;
      gap_q   <= '0;
`ifdef GPIOEMU_BUS_MASTER_READ_L_EN
      ones_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      a2_q    <= a2_d;
      w_q     <= w_d;
      valid_q <= valid_d;
      poll_q  <= poll_d;
      gap_q   <= gap_d;
`ifdef GPIOEMU_BUS_MASTER_READ_L_EN
      ones_q  <= ones_d;
`endif
    end
  end

  assign poll_inc = (poll_q == 16'hFFFF) ? poll_q : poll_q + 16'd1;

  // Each transfer state issues the next transfer on ack so transfers run back to back.
  always_comb begin
    state_d  = state_q;
    a2_d     = a2_q;
    w_d      = w_q;
    valid_d  = valid_q;
    poll_d   = poll_q;
    gap_d    = gap_q;
`ifdef GPIOEMU_BUS_MASTER_READ_L_EN
    ones_d   = ones_q;
`endif
    go       = 1'b0;
    go_kind  = XFER_WR;
    go_addr  = '0;
    go_wdata = '0;
    unique case (state_q)
      StIdle: if (start) begin
        state_d  = StWrA1;
        a2_d     = a2;
        poll_d   = '0;
        go       = 1'b1;
        go_addr  = ADDR_A1;
        go_wdata = {8'd0, a1};
      end
      StWrA1: if (ack) begin
        state_d  = StWrA2;
        go       = 1'b1;
        go_addr  = ADDR_A2;
        go_wdata = {8'd0, a2_q};
      end
      StWrA2: if (ack) begin
        state_d = StWrGo;
        go      = 1'b1;
        go_addr = ADDR_CTRL;
      end
      StWrGo: if (ack) begin
        state_d = StPoll;
        go      = 1'b1;
        go_kind = XFER_RD;
        go_addr = ADDR_CTRL;
      end
      StPoll: if (ack) begin
        if (rdata[STAT_READY]) begin
          valid_d = rdata[STAT_VALID];
          state_d = StRdW;
          go      = 1'b1;
          go_kind = XFER_RD;
          go_addr = ADDR_W;
        end else begin
          poll_d = poll_inc;
          if ({16'd0, poll_inc} >= POLL_MAX) begin
            state_d = StTimeout;
          end else if (POLL_GAP == 0) begin
            go      = 1'b1;
            go_kind = XFER_RD;
            go_addr = ADDR_CTRL;
          end else begin
            state_d = StGap;
            gap_d   = '0;
          end
        end
      end
      StGap: begin
        if (gap_q == 16'(POLL_GAP - 1)) begin
          state_d = StPoll;
          go      = 1'b1;
          go_kind = XFER_RD;
          go_addr = ADDR_CTRL;
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end
      StRdW: if (ack) begin
        w_d = rdata;
`ifdef GPIOEMU_BUS_MASTER_READ_L_EN
        state_d = StRdL;
        go      = 1'b1;
        go_kind = XFER_RD;
        go_addr = ADDR_L;
`else
        state_d = StDone;
`endif
      end
`ifdef GPIOEMU_BUS_MASTER_READ_L_EN
      StRdL: if (ack) begin
        ones_d  = rdata[23:0];
        state_d = StDone;
      end
`endif
      StDone, StTimeout: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  gpioemu_bus_xfer #(
    .STROBE_CYCLES(STROBE_CYCLES)
  ) u_xfer (
    .clk       (clk),
    .n_reset   (n_reset),
    .go_i      (go),
    .is_read_i (go_kind == XFER_RD),
    .addr_i    (go_addr),
    .wdata_i   (go_wdata),
    .sdata_rd_i(sdata_rd),
    .rdata_o   (rdata),
    .ack_o     (ack),
    .saddress_o(saddress),
    .swr_o     (swr),
    .srd_o     (srd),
    .sdata_wr_o(sdata_wr)
  );

  assign busy    = !(state_q inside {StIdle, StDone, StTimeout});
  assign done    = (state_q == StDone);
  assign timeout = (state_q == StTimeout);
  assign w       = w_q;
  assign valid   = valid_q;
`ifdef GPIOEMU_BUS_MASTER_READ_L_EN
  assign ones    = ones_q;
`else
  assign ones    = '0;
`endif

endmodule

// File: tb/tb_gpioemu_bus_master.sv
// Directed bench: three masters (strobe 2/1/3) share stimulus, each with its own peripheral model.
module tb_gpioemu_bus_master;
  localparam int unsigned PollMax = 3;
  localparam int unsigned PollGap = 4;
`ifdef GPIOEMU_BUS_MASTER_READ_L_EN
  localparam int NXfer = 6;
  localparam bit LEn   = 1'b1;
`else
  localparam int NXfer = 5;
  localparam bit LEn   = 1'b0;
`endif
  localparam int Lat0 = NXfer * 4;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic        start = 1'b0;
  logic [23:0] a1 = '0;
  logic [23:0] a2 = '0;
  int          m_need = 0;
  logic        m_vbit = 1'b0;
  logic [23:0] m_ones = '0;
  logic [2:0]  idle_v;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int Strobe = (g == 0) ? 2 : (g == 1) ? 1 : 3;
    logic        busy, done, timeout, valid, swr, srd, strb;
    logic [31:0] w, sdata_wr, sdata_rd;
    logic [23:0] ones;
    logic [15:0] saddress;
    logic [23:0] op1 = '0, op2 = '0;
    logic [47:0] prod;
    int          polls = 0, nlog = 0, ndone = 0, nstrb = 0, bad = 0, width = 0;
    logic [48:0] xlog [256];
    logic        strb_p = 1'b0, rd_p = 1'b0;
    logic [15:0] addr_p = '0, strb_addr = '0;

    gpioemu_bus_master #(
      .STROBE_CYCLES(Strobe),
      .POLL_MAX     (PollMax),
      .POLL_GAP     (PollGap)
    ) u_dut (
      .clk     (clk),
      .n_reset (n_reset),
      .start   (start),
      .a1      (a1),
      .a2      (a2),
      .busy    (busy),
      .done    (done),
      .timeout (timeout),
      .w       (w),
      .ones    (ones),
      .valid   (valid),
      .saddress(saddress),
      .swr     (swr),
      .srd     (srd),
      .sdata_wr(sdata_wr),
      .sdata_rd(sdata_rd)
    );

    assign prod      = op1 * op2;
    assign strb      = srd | swr;
    assign idle_v[g] = !busy && !done && !timeout;

    always_comb begin
      sdata_rd = '0;
      case (saddress)
        16'h03A0: sdata_rd = {30'd0, (polls >= m_need), m_vbit};
        16'h0390: sdata_rd = prod[31:0];
        16'h0398: sdata_rd = {8'd0, m_ones};
        default:  sdata_rd = '0;
      endcase
    end

    // Peripheral register capture plus bus-protocol monitor, sampled on the falling edge.
    always @(negedge clk) begin
      strb_p <= strb;
      rd_p   <= srd;
      addr_p <= saddress;
      if (!n_reset) begin
        strb_p <= 1'b0;
        width  <= 0;
      end else begin
        if (done) ndone <= ndone + 1;
        if (srd && swr) bad <= bad + 1;
        if (!busy && (saddress != 16'h0 || sdata_wr != 32'h0)) bad <= bad + 1;
        if (strb) begin
          width <= width + 1;
          if (!strb_p) begin
            strb_addr <= saddress;
            if (addr_p != saddress || saddress == 16'h0) bad <= bad + 1;
          end else if (saddress != strb_addr) begin
            bad <= bad + 1;
          end
        end else if (strb_p) begin
          width <= 0;
          nstrb <= nstrb + 1;
          if (width != Strobe || saddress != strb_addr) bad <= bad + 1;
          if (nlog < 256) xlog[nlog] <= {rd_p, saddress, rd_p ? sdata_rd : sdata_wr};
          nlog <= nlog + 1;
          if (!rd_p && saddress == 16'h037F) op1 <= sdata_wr[23:0];
          if (!rd_p && saddress == 16'h0388) op2 <= sdata_wr[23:0];
          if (!rd_p && saddress == 16'h03A0) polls <= 0;
          if (rd_p && saddress == 16'h03A0) polls <= polls + 1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_log(input string tag, input int idx, input logic [48:0] exp);
    logic [48:0] e;
    e = g_inst[0].xlog[idx];
    check(tag, e, exp);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (&idle_v) begin
        ok = 1'b1;
        break;
      end
    end
    check("idle_wait", ok, 1);
  endtask

  task automatic run(input logic [23:0] x1, input logic [23:0] x2, input bit poke,
                     output int lat, output bit got_done, output bit got_tmo);
    wait_idle();
    @(negedge clk);
    a1 = x1;
    a2 = x2;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    got_done = 1'b0;
    got_tmo = 1'b0;
    for (int i = 1; i <= 400; i++) begin
      @(posedge clk);
      #1;
      if (poke && i == 7) start = 1'b1;
      if (poke && i == 8) start = 1'b0;
      if (g_inst[0].done || g_inst[0].timeout) begin
        lat = i;
        got_done = g_inst[0].done;
        got_tmo = g_inst[0].timeout;
        break;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, base, nd, nrd;
    bit gd, gt, found;
    logic [48:0] e;

    repeat (3) @(negedge clk);
    check("rst_ctrl", {g_inst[0].busy, g_inst[0].done, g_inst[0].timeout, g_inst[0].valid,
                       g_inst[0].swr, g_inst[0].srd}, 6'b0);
    check("rst_w", g_inst[0].w, 32'h0);
    check("rst_ones", g_inst[0].ones, 24'h0);
    check("rst_bus", {g_inst[0].saddress, g_inst[0].sdata_wr}, 48'h0);
    n_reset = 1'b1;

    // 3*5, ready on first poll
    m_need = 0; m_vbit = 1'b1; m_ones = 24'd4;
    base = g_inst[0].nlog;
    run(24'd3, 24'd5, 1'b0, lat, gd, gt);
    check("t1_done", {gd, gt}, 2'b10);
    check("t1_latency", lat, Lat0);
    check("t1_w", g_inst[0].w, 32'h0000000F);
    check("t1_ones", g_inst[0].ones, LEn ? 24'd4 : 24'd0);
    check("t1_valid", g_inst[0].valid, 1'b1);
    check("t1_nxfer", g_inst[0].nlog - base, NXfer);
    chk_log("t1_x0", base + 0, {1'b0, 16'h037F, 32'h00000003});
    chk_log("t1_x1", base + 1, {1'b0, 16'h0388, 32'h00000005});
    chk_log("t1_x2", base + 2, {1'b0, 16'h03A0, 32'h00000000});
    chk_log("t1_x3", base + 3, {1'b1, 16'h03A0, 32'h00000003});
    chk_log("t1_x4", base + 4, {1'b1, 16'h0390, 32'h0000000F});
`ifdef GPIOEMU_BUS_MASTER_READ_L_EN
    chk_log("t1_x5", base + 5, {1'b1, 16'h0398, 32'h00000004});
`endif

    // Max operands, status 2'b10
    m_vbit = 1'b0; m_ones = 24'd7;
    run(24'hFFFFFF, 24'hFFFFFF, 1'b0, lat, gd, gt);
    check("t2_done", {gd, gt}, 2'b10);
    check("t2_w", g_inst[0].w, 32'hFE000001);
    check("t2_valid", g_inst[0].valid, 1'b0);
    check("t2_ones", g_inst[0].ones, LEn ? 24'd7 : 24'd0);

    // Ready on third poll: two gaps of PollGap plus two extra transfers
    m_need = 2; m_vbit = 1'b1; m_ones = 24'd1;
    run(24'h001000, 24'h000010, 1'b0, lat, gd, gt);
    check("t3_done", {gd, gt}, 2'b10);
    check("t3_latency", lat, Lat0 + 16);
    check("t3_w", g_inst[0].w, 32'h00010000);
    check("t3_valid", g_inst[0].valid, 1'b1);

    // Never ready: timeout after PollMax status reads, results untouched
    m_need = 99; m_ones = 24'd9;
    base = g_inst[0].nlog;
    run(24'd11, 24'd13, 1'b0, lat, gd, gt);
    check("t4_timeout", {gd, gt}, 2'b01);
    check("t4_latency", lat, 32);
    check("t4_busy", g_inst[0].busy, 1'b0);
    nrd = 0;
    for (int i = base; i < g_inst[0].nlog; i++) begin
      e = g_inst[0].xlog[i];
      if (e[48] && e[47:32] == 16'h03A0) nrd++;
    end
    check("t4_polls", nrd, 3);
    check("t4_w", g_inst[0].w, 32'h00010000);
    check("t4_ones", g_inst[0].ones, LEn ? 24'd1 : 24'd0);
    check("t4_valid", g_inst[0].valid, 1'b1);

    // start pulsed while busy is dropped
    m_need = 0; m_ones = 24'd2;
    wait_idle();
    base = g_inst[0].nlog;
    nd = g_inst[0].ndone;
    run(24'd6, 24'd7, 1'b1, lat, gd, gt);
    wait_idle();
    repeat (10) @(negedge clk);
    check("t5_ndone", g_inst[0].ndone - nd, 1);
    check("t5_nxfer", g_inst[0].nlog - base, NXfer);
    check("t5_w", g_inst[0].w, 32'h0000002A);

    // start held across the done cycle is accepted only on the following cycle
    run(24'd2, 24'd2, 1'b0, lat, gd, gt);
    start = 1'b1;
    @(posedge clk);
    #1 check("t6_done_start_ignored", g_inst[0].busy, 1'b0);
    @(posedge clk);
    #1 check("t6_accept_after_done", g_inst[0].busy, 1'b1);
    start = 1'b0;
    wait_idle();
    check("t6_w", g_inst[0].w, 32'h00000004);

    // Reset during the WR_A2 strobe
    @(negedge clk);
    a1 = 24'd9; a2 = 24'd10; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (g_inst[0].swr && g_inst[0].saddress == 16'h0388) begin
        found = 1'b1;
        break;
      end
    end
    check("t7_found_wr_a2", found, 1'b1);
    #2 n_reset = 1'b0;
    #1;
    check("t7_swr_drop", {g_inst[0].swr, g_inst[0].srd}, 2'b00);
    check("t7_ctrl", {g_inst[0].busy, g_inst[0].done, g_inst[0].timeout, g_inst[0].valid}, 4'b0);
    check("t7_bus", {g_inst[0].saddress, g_inst[0].sdata_wr}, 48'h0);
    check("t7_res", {g_inst[0].w, g_inst[0].ones}, 56'h0);
    nd = g_inst[0].ndone;
    repeat (3) @(negedge clk);
    n_reset = 1'b1;
    repeat (20) @(negedge clk);
    check("t7_no_done", g_inst[0].ndone - nd, 0);
    base = g_inst[0].nlog;
    run(24'd2, 24'd3, 1'b0, lat, gd, gt);
    check("t7_restart_done", {gd, gt}, 2'b10);
    chk_log("t7_restart_a1", base, {1'b0, 16'h037F, 32'h00000002});
    check("t7_w", g_inst[0].w, 32'h00000006);

    // Protocol monitors on all three strobe widths
    wait_idle();
    check("proto_s2", g_inst[0].bad, 0);
    check("proto_s1", g_inst[1].bad, 0);
    check("proto_s3", g_inst[2].bad, 0);
    check("strobes_s1", g_inst[1].nstrb > 20, 1'b1);
    check("strobes_s3", g_inst[2].nstrb > 20, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpioemu_bus_master.md
Name: gpioemu_bus_master

Overview:
- Bus initiator that drives the multiplier peripheral's slave interface (saddress/srd/swr/sdata) from the initiator side.
- One `start` request runs the full sequence: load A1 and A2, trigger, poll status until ready, read product W and ones-count L.
- Results are presented to the local requester with a one-cycle `done` pulse.
- Used as the on-chip driver for the emulated GPIO multiplier, and as the reusable bus driver in its benches.

Parameters:
- STROBE_CYCLES, 2, clk cycles srd/swr held high per transfer (>=1).
- POLL_MAX, 1024, maximum status reads before timeout (>=1).
- POLL_GAP, 4, idle clk cycles between status reads (>=0).
- ADDR_A1, 16'h037F, first-argument register.
- ADDR_A2, 16'h0388, second-argument register.
- ADDR_CTRL, 16'h03A0, trigger write / status read.
- ADDR_W, 16'h0390, product low word.
- ADDR_L, 16'h0398, ones count.

Ports:
- clk  in  1  system clock
- n_reset  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- a1  in  24  operand 1, captured on accepted start
- a2  in  24  operand 2, captured on accepted start
- busy  out  1  high from accepted start until done/timeout pulse
- done  out  1  one-cycle pulse, results valid
- timeout  out  1  one-cycle pulse, poll limit reached
- w  out  32  product low word
- ones  out  24  ones count
- valid  out  1  status bit0 sampled at last poll (product fits 32 bits)
- saddress  out  16  bus address
- swr  out  1  write strobe
- srd  out  1  read strobe
- sdata_wr  out  32  write data (to peripheral sdata_in)
- sdata_rd  in  32  read data (from peripheral sdata_out)

Behaviour:
- Reset, asynchronous, n_reset low:
  - All outputs 0; FSM in IDLE.
  - Reset mid-transfer drops srd/swr in the same instant; no completion pulse follows.
- Transfer timing, every transfer = SETUP(1) + STROBE(STROBE_CYCLES) + HOLD(1) cycles:
  - saddress and sdata_wr are stable for all three phases.
  - The strobe is high only in STROBE.
  - Read data is captured from sdata_rd on the clk edge that ends STROBE.
  - srd and swr are never high together.
  - Outside transfers, saddress = 0 and sdata_wr = 0.
- FSM: IDLE -> WR_A1 -> WR_A2 -> WR_GO -> POLL -> (GAP -> POLL)* -> RD_W -> RD_L -> DONE -> IDLE.
  - IDLE: start=1 captures a1/a2, busy=1.
  - WR_A1, WR_A2: write operand zero-extended to 32 bits.
  - WR_GO: write ADDR_CTRL, data 0.
  - POLL: read ADDR_CTRL.
    - Status bit1=1 (ready): latch bit0 into valid, go to RD_W.
    - Else: increment poll counter. Counter == POLL_MAX -> TIMEOUT; otherwise wait POLL_GAP cycles and repeat.
  - RD_W: w <= sdata_rd.
  - RD_L: ones <= sdata_rd[23:0].
  - DONE: done=1 for 1 cycle, busy=0 in the same cycle.
  - TIMEOUT: timeout=1 for 1 cycle, busy=0. w/ones/valid keep their previous values.
- start while busy is ignored, not queued. start on the done/timeout cycle is ignored; it is accepted from the next cycle.
- Result latency with zero polls failing = 6 transfers × (STROBE_CYCLES+2); 24 cycles at default.
- Poll counter is 16 bits and saturates; it is cleared on each accepted start.
- sdata_rd bits [31:2] are ignored during status reads.

Optional Feature:
- Macro: GPIOEMU_BUS_MASTER_READ_L_EN.
- Defined: RD_L is performed as above.
- Undefined:
  - RD_W goes directly to DONE.
  - ones is held at 0.
  - Latency is 5 transfers.

Decomposition:
- Shared package gpioemu_pkg:
  - register address constants ADDR_*;
  - status bit positions (STAT_READY=1, STAT_VALID=0);
  - FSM state enum;
  - transfer-type enum (XFER_RD, XFER_WR).
- Sub-module gpioemu_bus_xfer: single-transfer engine.
  - Inputs: go, is_read, addr, wdata.
  - Outputs: rdata, ack (1-cycle pulse at end of HOLD).
  - Owns the SETUP/STROBE/HOLD phases and strobe generation.
- The top-level FSM sequences the transfers.

Test Plan:
- a1=3, a2=5, peripheral model ready on first poll:
  - Transfers: writes to 037F/0388/03A0, reads 03A0/0390/0398.
  - w=0x0000000F, ones=4, valid=1.
  - done after 24 cycles.
- a1=a2=0xFFFFFF, model status=2'b10:
  - w=0xFE000001, valid=0, ones=7.
- Model returns status 0 forever, POLL_MAX=3, POLL_GAP=4:
  - Exactly 3 reads of 03A0, then timeout pulse, busy falls.
  - w, ones, valid unchanged.
- start pulsed again while busy:
  - No extra transfers; one done only.
- n_reset asserted during STROBE of WR_A2:
  - swr falls immediately; all outputs 0.
  - New start after release restarts at WR_A1.
- Strobe timing at STROBE_CYCLES=1 and 3:
  - Address stable one cycle before and after each strobe.
  - srd and swr never high together.
  - Strobe width matches STROBE_CYCLES.
